// File: rtl/hamming_burst_ctrl_pkg.sv
// Shared types and codeword layout helpers for the Hamming(15,11) burst controller.
// Codeword position p (1..15) lives at bit [CODE_W-p]; parity sits at positions 1, 2, 4, 8.
package hamming_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT
  } state_e;

  localparam int CODE_W = 15;
  localparam int DATA_W = 11;
  localparam int POS_W  = 4;

  // Non-parity positions, ascending; the first entry maps to the data MSB.
  localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [DATA_W-1:0] raw_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[POS_W'(DATA_W - 1 - i)] = code[POS_W'(CODE_W - DATA_POS[i])];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_burst_ctrl_ip.sv
// Combinational single-error-correcting Hamming decoder (15-bit codeword, 11-bit data).
// The syndrome is the XOR of the positions of all set bits; a non-zero value names the bad bit.
module HAMMING_IP
  import hamming_burst_ctrl_pkg::*;
#(
  parameter int IP_BIT = 11
) (
  input  logic [IP_BIT+3:0] in_code,
  output logic [IP_BIT-1:0] out_code
);

  localparam int CW = IP_BIT + 4;

  logic [POS_W-1:0] syndrome;
  logic [CW-1:0]    fixed;

  always_comb begin
    syndrome = '0;
    for (int p = 1; p <= CW; p++) begin
      if (in_code[POS_W'(CW - p)]) syndrome = syndrome ^ POS_W'(p);
    end
    fixed = in_code;
    if (syndrome != '0) begin
      fixed[POS_W'(CW) - syndrome] = ~in_code[POS_W'(CW) - syndrome];
    end
  end

  assign out_code = raw_data(fixed);

endmodule

// File: rtl/hamming_burst_ctrl.sv
// Burst controller: collects BURST codewords through one shared Hamming decoder, buffers the
// decoded words with a per-word correction flag, then replays them with a corrected-word count.
module hamming_burst_ctrl
  import hamming_burst_ctrl_pkg::*;
#(
  parameter int IP_BIT = 11,
  parameter int BURST  = 8,
  parameter int CNT_W  = $clog2(BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IP_BIT+3:0] in_code,
  output logic              out_valid,
  output logic [IP_BIT-1:0] out_code,
  output logic              out_fix,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_fix_cnt
);

  localparam int PTR_W = $clog2(BURST);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BURST - 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fix_cnt_q, fix_cnt_d;
  logic [IP_BIT:0]   result_q [BURST];

  logic              out_valid_q, out_valid_d;
  logic [IP_BIT-1:0] out_code_q, out_code_d;
  logic              out_fix_q, out_fix_d;
  logic              out_last_q, out_last_d;
  logic [CNT_W-1:0]  out_fix_cnt_q, out_fix_cnt_d;

  logic              sample;
  logic [IP_BIT+3:0] ip_code;
  logic [IP_BIT-1:0] dec_data;
  logic              dec_fix;

  assign sample  = in_valid && (state_q == IDLE || state_q == LOAD);
  // Park the decoder input at zero outside sampling cycles so it does not toggle.
  assign ip_code = sample ? in_code : '0;

  HAMMING_IP #(.IP_BIT(IP_BIT)) u_ip (
    .in_code  (ip_code),
    .out_code (dec_data)
  );

  assign dec_fix = (dec_data != raw_data(in_code));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned
    // and no latch can be inferred.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fix_cnt_d     = fix_cnt_q;
    out_valid_d   = 1'b0;
    out_code_d    = '0;
    out_fix_d     = 1'b0;
    out_last_d    = 1'b0;
    out_fix_cnt_d = '0;

    unique case (state_q)
      IDLE: begin
        if (sample) begin
          fix_cnt_d = CNT_W'(dec_fix);
          wr_ptr_d  = PTR_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (sample) begin
          fix_cnt_d = fix_cnt_q + CNT_W'(dec_fix);
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = OUT;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
        end
      end
      OUT: begin
        out_valid_d = 1'b1;
        out_code_d  = result_q[rd_ptr_q][IP_BIT:1];
        out_fix_d   = result_q[rd_ptr_q][0];
        if (rd_ptr_q == LAST_PTR) begin
          out_last_d    = 1'b1;
          out_fix_cnt_d = fix_cnt_q;
          rd_ptr_d      = '0;
          fix_cnt_d     = '0;
          state_d       = IDLE;
        end else begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fix_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_code_q    <= '0;
      out_fix_q     <= 1'b0;
      out_last_q    <= 1'b0;
      out_fix_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fix_cnt_q     <= fix_cnt_d;
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      out_fix_q     <= out_fix_d;
      out_last_q    <= out_last_d;
      out_fix_cnt_q <= out_fix_cnt_d;
    end
  end

  // NOTE: the result buffer is deliberately left out of reset; every slot is written before
  // it is read in a burst, so a reset would only cost a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (sample) result_q[wr_ptr_q] <= {dec_data, dec_fix};
  end

  assign out_valid   = out_valid_q;
  assign out_code    = out_code_q;
  assign out_fix     = out_fix_q;
  assign out_last    = out_last_q;
  assign out_fix_cnt = out_fix_cnt_q;

endmodule

// File: tb/tb_hamming_burst_ctrl.sv
// Directed bench for hamming_burst_ctrl: clean, corrected, parity-error, gapped, streaming
// and reset-interrupted bursts, each against hand-computed decodes.
module tb_hamming_burst_ctrl;

  localparam int IP_BIT = 11;
  localparam int BURST  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [IP_BIT+3:0] in_code;
  logic              out_valid;
  logic [IP_BIT-1:0] out_code;
  logic              out_fix;
  logic              out_last;
  logic [CNT_W-1:0]  out_fix_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [IP_BIT-1:0] exp_code [BURST];
  logic              exp_fix  [BURST];
  logic [CNT_W-1:0]  exp_cnt;

  hamming_burst_ctrl #(.IP_BIT(IP_BIT), .BURST(BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .out_valid   (out_valid),
    .out_code    (out_code),
    .out_fix     (out_fix),
    .out_last    (out_last),
    .out_fix_cnt (out_fix_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [14:0] w);
    in_valid = 1'b1;
    in_code  = w;
    step();
    in_valid = 1'b0;
    in_code  = '0;
  endtask

  // Word 0 sits in the most significant slice of each packed list.
  task automatic send_burst(input logic [15*BURST-1:0] ws);
    for (int i = 0; i < BURST; i++) send(ws[(BURST-1-i)*15 +: 15]);
  endtask

  task automatic set_exp(input logic [11*BURST-1:0] codes, input logic [BURST-1:0] fixes,
                         input logic [CNT_W-1:0] cnt);
    for (int i = 0; i < BURST; i++) begin
      exp_code[i] = codes[(BURST-1-i)*11 +: 11];
      exp_fix[i]  = fixes[BURST-1-i];
    end
    exp_cnt = cnt;
  endtask

  task automatic check_beat(input int i, input string tag);
    chk($sformatf("%s.valid%0d", tag, i), 16'(out_valid), 16'h1);
    chk($sformatf("%s.code%0d", tag, i), 16'(out_code), 16'(exp_code[i]));
    chk($sformatf("%s.fix%0d", tag, i), 16'(out_fix), 16'(exp_fix[i]));
    chk($sformatf("%s.last%0d", tag, i), 16'(out_last), 16'(i == BURST - 1));
    chk($sformatf("%s.cnt%0d", tag, i), 16'(out_fix_cnt),
        (i == BURST - 1) ? 16'(exp_cnt) : 16'h0);
  endtask

  // Called right after the edge that samples the last word of a burst.
  task automatic check_burst(input string tag);
    chk($sformatf("%s.latency", tag), 16'(out_valid), 16'h0);
    for (int i = 0; i < BURST; i++) begin
      step();
      check_beat(i, tag);
    end
    step();
    chk($sformatf("%s.after", tag), 16'(out_valid | out_last), 16'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    step();
    step();
    chk("rst.valid", 16'(out_valid), 16'h0);
    chk("rst.code", 16'(out_code), 16'h0);
    chk("rst.fix", 16'(out_fix), 16'h0);
    chk("rst.last", 16'(out_last), 16'h0);
    chk("rst.cnt", 16'(out_fix_cnt), 16'h0);
    rst_n = 1'b1;
    step();

    // Clean alternating burst.
    set_exp({11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF},
            8'b0000_0000, 4'd0);
    send_burst({15'h0000, 15'h7FFF, 15'h0000, 15'h7FFF,
                15'h0000, 15'h7FFF, 15'h0000, 15'h7FFF});
    check_burst("clean");

    // Single data-bit errors at positions 15, 3 and 15 (of an all-ones word).
    set_exp({11'h000, 11'h000, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000},
            8'b1110_0000, 4'd3);
    send_burst({15'h0001, 15'h1000, 15'h7FFE, 15'h0000,
                15'h0000, 15'h0000, 15'h0000, 15'h0000});
    check_burst("data");

    // Parity-bit errors at positions 1 and 8 are corrected but not flagged.
    set_exp({11'h000, 11'h7FF, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000},
            8'b0000_0000, 4'd0);
    send_burst({15'h4000, 15'h7F7F, 15'h0000, 15'h0000,
                15'h0000, 15'h0000, 15'h0000, 15'h0000});
    check_burst("parity");

    // Gapped clean burst must replay exactly like the contiguous one.
    set_exp({11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF},
            8'b0000_0000, 4'd0);
    send(15'h0000);
    send(15'h7FFF);
    repeat (3) begin
      step();
      chk("gap.a", 16'(out_valid), 16'h0);
    end
    send(15'h0000);
    send(15'h7FFF);
    send(15'h0000);
    send(15'h7FFF);
    repeat (5) begin
      step();
      chk("gap.b", 16'(out_valid), 16'h0);
    end
    send(15'h0000);
    send(15'h7FFF);
    check_burst("gap");

    // Continuous in_valid: words 8..15 arrive during OUT and must be dropped.
    set_exp({11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000},
            8'b1111_1110, 4'd7);
    for (int c = 0; c < 3 * BURST; c++) begin
      in_valid = 1'b1;
      in_code  = (c < 15) ? 15'(1 << c) : (15'h7FFF ^ 15'(1 << (c - 15)));
      step();
      if (c >= BURST && c < 2 * BURST) check_beat(c - BURST, "stream1");
      else chk($sformatf("stream.idle%0d", c), 16'(out_valid), 16'h0);
    end
    in_valid = 1'b0;
    in_code  = '0;
    set_exp({11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF},
            8'b1111_1101, 4'd7);
    check_burst("stream2");

    // Reset while beat 4 is on the outputs.
    set_exp({11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF, 11'h000, 11'h7FF},
            8'b0000_0000, 4'd0);
    send_burst({15'h0000, 15'h7FFF, 15'h0000, 15'h7FFF,
                15'h0000, 15'h7FFF, 15'h0000, 15'h7FFF});
    chk("abort.latency", 16'(out_valid), 16'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_beat(i, "abort");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort.valid", 16'(out_valid), 16'h0);
    chk("abort.code", 16'(out_code), 16'h0);
    chk("abort.last", 16'(out_last), 16'h0);
    chk("abort.cnt", 16'(out_fix_cnt), 16'h0);
    step();
    chk("abort.hold", 16'(out_valid), 16'h0);
    rst_n = 1'b1;
    repeat (2) begin
      step();
      chk("abort.quiet", 16'(out_valid), 16'h0);
    end

    // Fresh burst after reset: counter must start from zero.
    set_exp({11'h001, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000},
            8'b0100_0000, 4'd1);
    send_burst({15'h6881, 15'h0001, 15'h0000, 15'h0000,
                15'h0000, 15'h0000, 15'h0000, 15'h0000});
    check_burst("post");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
